schmitt_period_detector: RTL and testbench

SCHMITT_PERIOD_DETECTOR -- requirements
Module: schmitt_period_detector

---
 rtl/discrete_pkg.sv | 18 +
 rtl/schmitt_trigger.sv | 37 +++
 rtl/schmitt_period_detector.sv | 130 +++++++++++++
 tb/tb_schmitt_period_detector.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared definitions for the discrete audio-circuit models: FSM state type
// and the millivolt-to-sample scaling used to derive comparator thresholds.
package discrete_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } det_state_e;

  // Sample full scale: 1 <<< FS_SHIFT counts correspond to VCC.
  localparam int FS_SHIFT   = 14;
  localparam int FULL_SCALE = 1 << FS_SHIFT;

  function automatic int mv_to_code(input int mv, input int vcc);
    return (mv <<< FS_SHIFT) / (vcc * 1000);
  endfunction

endpackage

// File: rtl/schmitt_trigger.sv
// Hysteresis comparator: output sets at or above TH_HI, clears at or below
// TH_LO, holds in between. Evaluated only on sample-strobe cycles.
module schmitt_trigger #(
  parameter int TH_HI = 4096,
  parameter int TH_LO = 2048
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic               level
);

  logic level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (audio_clk_en) begin
      if (int'(in) >= TH_HI) begin
        level_d = 1'b1;
      end else if (int'(in) <= TH_LO) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/schmitt_period_detector.sv
// Measures rising-to-rising period and high time of a hysteresis-squared
// audio signal, in samples, with a no-signal timeout.
module schmitt_period_detector
  import discrete_pkg::*;
#(
  parameter int SAMPLE_RATE        = 48000,
  parameter int VCC                = 12,
  parameter int V_T_PLUS_MV        = 3000,
  parameter int V_T_MINUS_MV       = 1500,
  parameter int MAX_PERIOD_SAMPLES = 48000
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic               level,
  output logic [15:0]        period_samples,
  output logic [15:0]        high_samples,
  output logic               period_valid,
  output logic               no_signal
);

  localparam int TH_HI = mv_to_code(V_T_PLUS_MV, VCC);
  localparam int TH_LO = mv_to_code(V_T_MINUS_MV, VCC);
  localparam logic [15:0] MAX_CNT = 16'(MAX_PERIOD_SAMPLES);
  localparam int unused_sample_rate = SAMPLE_RATE;

  det_state_e  state_q, state_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] hi_cnt_q, hi_cnt_d;
  logic [15:0] period_q, period_d;
  logic [15:0] high_q, high_d;
  logic        valid_q, valid_d;
  logic        no_sig_q, no_sig_d;
  logic        en_q;
  logic        lvl_prev_q, lvl_prev_d;
  logic        rise, fall;

  schmitt_trigger #(
    .TH_HI(TH_HI),
    .TH_LO(TH_LO)
  ) u_schmitt (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .in          (in),
    .level       (level)
  );

  // The comparator registers on the strobe; edges are evaluated the clock
  // after, against the level seen at the previous strobe.
  assign rise       = en_q &  level & ~lvl_prev_q;
  assign fall       = en_q & ~level &  lvl_prev_q;
  assign lvl_prev_d = en_q ? level : lvl_prev_q;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    no_sig_d  = no_sig_q;
    if (en_q) begin
      case (state_q)
        SEARCH: begin
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = 16'd1;
            hi_cnt_d  = 16'd1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d  = per_cnt_q;
            per_cnt_d = 16'd1;
            hi_cnt_d  = 16'd1;
            no_sig_d  = 1'b0;
            valid_d   = 1'b1;
          end else if (per_cnt_q == MAX_CNT) begin
            state_d   = SEARCH;
            per_cnt_d = 16'd0;
            hi_cnt_d  = 16'd0;
            period_d  = 16'd0;
            high_d    = 16'd0;
            no_sig_d  = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + 16'd1;
            if (fall) begin
              high_d = hi_cnt_q;
            end else if (level) begin
              hi_cnt_d = hi_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q    <= SEARCH;
      per_cnt_q  <= 16'd0;
      hi_cnt_q   <= 16'd0;
      period_q   <= 16'd0;
      high_q     <= 16'd0;
      valid_q    <= 1'b0;
      no_sig_q   <= 1'b1;
      en_q       <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      no_sig_q   <= no_sig_d;
      en_q       <= audio_clk_en;
      lvl_prev_q <= lvl_prev_d;
    end
  end

  assign period_samples = period_q;
  assign high_samples   = high_q;
  assign period_valid   = valid_q;
  assign no_signal      = no_sig_q;

endmodule

// File: tb/tb_schmitt_period_detector.sv
// Directed self-checking bench for schmitt_period_detector (timeout set to 100).
module tb_schmitt_period_detector;

  localparam logic signed [15:0] V_HI = 16'sd6826;
  localparam logic signed [15:0] V_LO = 16'sd0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               en = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               level;
  logic [15:0]        period_samples;
  logic [15:0]        high_samples;
  logic               period_valid;
  logic               no_signal;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;

  schmitt_period_detector #(
    .SAMPLE_RATE       (48000),
    .VCC               (12),
    .V_T_PLUS_MV       (3000),
    .V_T_MINUS_MV      (1500),
    .MAX_PERIOD_SAMPLES(100)
  ) dut (
    .clk           (clk),
    .I_RSTn        (rst_n),
    .audio_clk_en  (en),
    .in            (sample_in),
    .level         (level),
    .period_samples(period_samples),
    .high_samples  (high_samples),
    .period_valid  (period_valid),
    .no_signal     (no_signal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (period_valid) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic put_sample(input logic signed [15:0] v);
    @(negedge clk);
    sample_in = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic put_run(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) put_sample(v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en = 1'b0;
    sample_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic lvl, input int per,
                               input int hi, input logic nos, input int nval);
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".period"}, 32'(period_samples), per);
    check({tag, ".high"}, 32'(high_samples), hi);
    check({tag, ".no_signal"}, 32'(no_signal), 32'(nos));
    check({tag, ".valid_cnt"}, valid_cnt, nval);
  endtask

  initial begin
    logic signed [15:0] seq [6];
    logic               exp_lvl [6];
    seq     = '{16'sd0, 16'sd3000, 16'sd5000, 16'sd3000, 16'sd2049, 16'sd2048};
    exp_lvl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst.valid", 32'(period_valid), 0);
    check_outputs("rst", 1'b0, 0, 0, 1'b1, 0);
    rst_n = 1'b1;

    // Hysteresis thresholds
    for (int i = 0; i < 6; i++) begin
      put_sample(seq[i]);
      check($sformatf("hyst[%0d]", i), 32'(level), 32'(exp_lvl[i]));
    end

    // Square wave 24 high / 24 low
    apply_reset();
    put_run(V_HI, 24);
    put_run(V_LO, 24);
    check_outputs("sq.p0", 1'b0, 0, 24, 1'b1, 0);
    put_run(V_HI, 24);
    put_run(V_LO, 24);
    check_outputs("sq.p1", 1'b0, 48, 24, 1'b0, 1);
    put_run(V_HI, 24);
    put_run(V_LO, 24);
    put_sample(V_HI);
    check_outputs("sq.p2", 1'b1, 48, 24, 1'b0, 3);

    // Reset mid-period
    put_run(V_HI, 10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.valid", 32'(period_valid), 0);
    check_outputs("mid_rst", 1'b0, 0, 0, 1'b1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    put_run(V_HI, 24);
    put_run(V_LO, 24);
    check_outputs("post_rst.1rise", 1'b0, 0, 24, 1'b1, 3);
    put_sample(V_HI);
    check_outputs("post_rst.2rise", 1'b1, 48, 24, 1'b0, 4);

    // Strobe idle with toggling input
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      sample_in = ((i % 2) == 0) ? V_HI : V_LO;
    end
    check_outputs("idle", 1'b1, 48, 24, 1'b0, 4);

    // Timeout after 100 samples without a rise
    put_run(V_HI, 99);
    check_outputs("pre_tmo", 1'b1, 48, 24, 1'b0, 4);
    put_sample(V_HI);
    check_outputs("tmo", 1'b1, 0, 0, 1'b1, 4);
    put_run(V_LO, 24);
    put_sample(V_HI);
    check_outputs("search_rise", 1'b1, 0, 0, 1'b1, 4);

    // Rise coinciding with the timeout sample
    put_run(V_HI, 49);
    put_run(V_LO, 50);
    put_sample(V_HI);
    check_outputs("rise_vs_tmo", 1'b1, 100, 50, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
